// File: rtl/half_shell_sweep_controller_if.sv
// Controller-side bus for the particle-filter front end: count memory lookup,
// reference buffer load, and neighbor read stream with pair-queue backpressure.
interface half_shell_sweep_controller_if #(
  parameter int ADDR_W = 7
);
  logic [7:0]        count_cell;
  logic [ADDR_W:0]   count_data;
  logic              ref_load;
  logic [ADDR_W-1:0] ref_addr;
  logic              nbr_valid;
  logic [7:0]        nbr_cell;
  logic [ADDR_W-1:0] nbr_addr;
  logic              stall;

  modport master (
    output count_cell, ref_load, ref_addr, nbr_valid, nbr_cell, nbr_addr,
    input  count_data, stall
  );

  modport slave (
    input  count_cell, ref_load, ref_addr, nbr_valid, nbr_cell, nbr_addr,
    output count_data, stall
  );
endinterface

// File: rtl/half_shell_sweep_controller.sv
// Walks every reference particle of one home cell against all particles of the
// 14 half-shell cells (home + 13 forward neighbors) on a 4x4x4 periodic grid.
module half_shell_sweep_controller #(
  parameter int ADDR_W  = 7,
  parameter int NUM_NBR = 14
) (
  input  logic                          fast_clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [7:0]                    home_cell,
  input  logic                          drain_idle,
  output logic                          busy,
  output logic                          done,
  half_shell_sweep_controller_if.master sw
);

  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] REF_CNT1  = 4'd1;
  localparam logic [3:0] REF_CNT2  = 4'd2;
  localparam logic [3:0] LOAD_REF  = 4'd3;
  localparam logic [3:0] NBR_CNT1  = 4'd4;
  localparam logic [3:0] NBR_CNT2  = 4'd5;
  localparam logic [3:0] SWEEP     = 4'd6;
  localparam logic [3:0] NEXT_CELL = 4'd7;
  localparam logic [3:0] DRAIN     = 4'd8;

  localparam logic [3:0] LAST_K      = 4'(NUM_NBR - 1);
  localparam int         HOLD_STAGES = 1;

  // Offsets are mod-4 field deltas: -1 wraps to 2'b11.
  localparam logic [1:0] M1 = 2'b11;
  localparam logic [1:0] Z0 = 2'b00;
  localparam logic [1:0] P1 = 2'b01;

  logic [3:0]          state;
  logic [5:0]          home_q;
  logic [ADDR_W:0]     ref_total, r, n_k, j;
  logic [3:0]          k;
  logic [HOLD_STAGES:0] vld_pipe;
  logic [1:0]          dx, dy, dz, cx, cy, cz;
  logic [7:0]          cur_cell;
  logic                unused_hi;

  // Bits [7:6] of the home id carry no coordinate information.
  assign unused_hi = ^home_cell[7:6];

  always_comb begin
    dx = Z0; dy = Z0; dz = Z0;
    if (k >= 4'd1 && k <= 4'd9) begin
      dz = P1;
      dy = (k <= 4'd3) ? M1 : (k <= 4'd6) ? Z0 : P1;
      dx = (k == 4'd1 || k == 4'd4 || k == 4'd7) ? M1 :
           (k == 4'd2 || k == 4'd5 || k == 4'd8) ? Z0 : P1;
    end else if (k >= 4'd10 && k <= 4'd12) begin
      dy = P1;
      dx = (k == 4'd10) ? M1 : (k == 4'd11) ? Z0 : P1;
    end else if (k == 4'd13) begin
      dx = P1;
    end
  end

  assign cx = home_q[1:0] + dx;
  assign cy = home_q[3:2] + dy;
  assign cz = home_q[5:4] + dz;
  assign cur_cell = {2'b00, cz, cy, cx};

  always_comb begin
    sw.count_cell = '0;
    if (state == REF_CNT1) sw.count_cell = {2'b00, home_q};
    if (state == NBR_CNT1) sw.count_cell = cur_cell;
    sw.ref_load  = (state == LOAD_REF);
    sw.ref_addr  = (state == LOAD_REF) ? r[ADDR_W-1:0] : '0;
    // Stall gates the strobe only; cell/addr keep presenting the pending read.
    sw.nbr_valid = (state == SWEEP) && !sw.stall;
    sw.nbr_cell  = (state == SWEEP) ? cur_cell : '0;
    sw.nbr_addr  = (state == SWEEP) ? j[ADDR_W-1:0] : '0;
  end

  always_ff @(posedge fast_clk) begin
    if (reset) begin
      state     <= IDLE;
      home_q    <= '0;
      ref_total <= '0;
      r         <= '0;
      n_k       <= '0;
      j         <= '0;
      k         <= '0;
      vld_pipe  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      // Tracks recent issues so done cannot beat the last pair into the queue.
      vld_pipe <= {vld_pipe[HOLD_STAGES-1:0], sw.nbr_valid};
      case (state)
        IDLE: if (start) begin
          home_q <= home_cell[5:0];
          done   <= 1'b0;
          busy   <= 1'b1;
          state  <= REF_CNT1;
        end
        REF_CNT1: state <= REF_CNT2;
        REF_CNT2: begin
          ref_total <= sw.count_data;
          r         <= '0;
          state     <= (sw.count_data == '0) ? DRAIN : LOAD_REF;
        end
        LOAD_REF: begin
          k     <= '0;
          state <= NBR_CNT1;
        end
        NBR_CNT1: state <= NBR_CNT2;
        NBR_CNT2: begin
          n_k   <= sw.count_data;
          j     <= '0;
          state <= (sw.count_data == '0) ? NEXT_CELL : SWEEP;
        end
        SWEEP: if (sw.nbr_valid) begin
          j <= j + 1'b1;
          if (j == n_k - 1'b1) state <= NEXT_CELL;
        end
        NEXT_CELL: begin
          if (k < LAST_K) begin
            k     <= k + 4'd1;
            state <= NBR_CNT1;
          end else if (r < ref_total - 1'b1) begin
            r     <= r + 1'b1;
            state <= LOAD_REF;
          end else begin
            state <= DRAIN;
          end
        end
        DRAIN: if (drain_idle && vld_pipe == '0) begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_half_shell_sweep_controller.sv
// Randomized bench for the half-shell sweep controller; an event-list model built
// from the half-shell rules is compared with what the bus actually emits.
module tb_half_shell_sweep_controller;
  localparam int AW = 7;

  logic       fast_clk = 1'b0;
  logic       reset, start, drain_idle, busy, done;
  logic [7:0] home_cell;

  half_shell_sweep_controller_if #(.ADDR_W(AW)) ifc ();

  half_shell_sweep_controller #(.ADDR_W(AW)) dut (
    .fast_clk  (fast_clk),
    .reset     (reset),
    .start     (start),
    .home_cell (home_cell),
    .drain_idle(drain_idle),
    .busy      (busy),
    .done      (done),
    .sw        (ifc)
  );

  always #5 fast_clk = ~fast_clk;

  int n_cmp = 0;
  int n_err = 0;

  // Count memory with one cycle of read latency.
  logic [AW:0] cnt_mem [256];
  always @(posedge fast_clk) ifc.count_data <= cnt_mem[ifc.count_cell];

  int   stall_mode = 0;
  logic stall_force = 1'b0;
  always @(posedge fast_clk) begin
    #1;
    ifc.stall = (stall_mode != 0) ? ($urandom_range(0, 3) == 0) : stall_force;
  end

  logic [17:0] evq [$];
  logic [17:0] exp_q [$];
  int overlap = 0;
  always @(negedge fast_clk) begin
    if (ifc.ref_load)  evq.push_back({2'b01, 8'h00, 1'b0, ifc.ref_addr});
    if (ifc.nbr_valid) evq.push_back({2'b10, ifc.nbr_cell, 1'b0, ifc.nbr_addr});
    if (ifc.ref_load && ifc.nbr_valid) overlap++;
  end

  int odx [14], ody [14], odz [14];

  task automatic init_shell();
    int n = 1;
    odx[0] = 0; ody[0] = 0; odz[0] = 0;
    for (int y = -1; y <= 1; y++)
      for (int x = -1; x <= 1; x++) begin
        odx[n] = x; ody[n] = y; odz[n] = 1; n++;
      end
    for (int x = -1; x <= 1; x++) begin
      odx[n] = x; ody[n] = 1; odz[n] = 0; n++;
    end
    odx[13] = 1; ody[13] = 0; odz[13] = 0;
  endtask

  function automatic logic [7:0] cell_of(input logic [7:0] h, input int k);
    int x, y, z;
    x = (int'(h[1:0]) + odx[k]) & 3;
    y = (int'(h[3:2]) + ody[k]) & 3;
    z = (int'(h[5:4]) + odz[k]) & 3;
    return 8'(z * 16 + y * 4 + x);
  endfunction

  task automatic build_exp(input logic [7:0] h);
    exp_q.delete();
    for (int r = 0; r < int'(cnt_mem[cell_of(h, 0)]); r++) begin
      exp_q.push_back({2'b01, 8'h00, 8'(r)});
      for (int k = 0; k < 14; k++) begin
        logic [7:0] c;
        c = cell_of(h, k);
        for (int jj = 0; jj < int'(cnt_mem[c]); jj++)
          exp_q.push_back({2'b10, c, 8'(jj)});
      end
    end
  endtask

  task automatic fill_counts(input int lo, input int hi);
    for (int i = 0; i < 256; i++) cnt_mem[i] = 8'($urandom_range(lo, hi));
  endtask

  task automatic pulse_start(input logic [7:0] h);
    @(posedge fast_clk); #1;
    home_cell = h; start = 1'b1;
    @(posedge fast_clk); #1;
    start = 1'b0; home_cell = 8'($urandom);
  endtask

  task automatic wait_done(input int maxc, output int cyc);
    cyc = 0;
    while (!done && cyc < maxc) begin
      @(negedge fast_clk); cyc++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; drain_idle = 1'b1; home_cell = 8'h00;
    repeat (3) @(posedge fast_clk);
    @(negedge fast_clk);
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_err++; $display("FAIL reset_status: got busy/done %b want 00", {busy, done});
    end
    n_cmp++;
    if ({ifc.ref_load, ifc.nbr_valid, ifc.count_cell} !== 10'h0) begin
      n_err++; $display("FAIL reset_strobes: got %h want 0", {ifc.ref_load, ifc.nbr_valid, ifc.count_cell});
    end
    n_cmp++;
    if ({ifc.ref_addr, ifc.nbr_cell, ifc.nbr_addr} !== 22'h0) begin
      n_err++; $display("FAIL reset_addrs: got %h want 0", {ifc.ref_addr, ifc.nbr_cell, ifc.nbr_addr});
    end
    @(posedge fast_clk); #1 reset = 1'b0;
  endtask

  task automatic test_empty();
    int cyc = 0;
    bit saw_busy = 0;
    fill_counts(0, 0);
    evq.delete();
    pulse_start(8'h00);
    while (!done && cyc < 20) begin
      @(negedge fast_clk); cyc++;
      if (busy) saw_busy = 1;
    end
    n_cmp++;
    if (!(done === 1'b1 && cyc <= 4)) begin
      n_err++; $display("FAIL empty_done_latency: got done=%b after %0d cycles want 1 within 4", done, cyc);
    end
    n_cmp++;
    if (!saw_busy || busy !== 1'b0) begin
      n_err++; $display("FAIL empty_busy_pulse: got saw=%0d busy_now=%b want 1/0", saw_busy, busy);
    end
    n_cmp++;
    if (evq.size() != 0) begin
      n_err++; $display("FAIL empty_events: got %0d want 0", evq.size());
    end
  endtask

  task automatic test_single_walk();
    logic [7:0] walk [14] = '{8'h15, 8'h20, 8'h21, 8'h22, 8'h24, 8'h25, 8'h26,
                              8'h28, 8'h29, 8'h2A, 8'h18, 8'h19, 8'h1A, 8'h16};
    int cyc;
    fill_counts(1, 1);
    build_exp(8'h15);
    evq.delete();
    pulse_start(8'h15);
    wait_done(2000, cyc);
    n_cmp++;
    if (evq.size() != 15 || done !== 1'b1) begin
      n_err++; $display("FAIL walk_len: got %0d events done=%b want 15 done=1", evq.size(), done);
    end else begin
      n_cmp++;
      if (evq[0] !== 18'h10000) begin
        n_err++; $display("FAIL walk_ref: got %h want 10000", evq[0]);
      end
      for (int k = 0; k < 14; k++) begin
        n_cmp++;
        if (evq[1+k] !== {2'b10, walk[k], 8'h00}) begin
          n_err++; $display("FAIL walk_cell k=%0d: got %h want %h", k, evq[1+k], {2'b10, walk[k], 8'h00});
        end
      end
    end
  endtask

  task automatic test_wrap();
    int cyc;
    fill_counts(1, 1);
    build_exp(8'h3F);
    evq.delete();
    pulse_start(8'h3F);
    wait_done(2000, cyc);
    n_cmp++;
    if (evq.size() != 15) begin
      n_err++; $display("FAIL wrap_len: got %0d want 15", evq.size());
    end else begin
      n_cmp++;
      if (evq[2][15:8] !== 8'h0A) begin n_err++; $display("FAIL wrap_k1: got %h want 0a", evq[2][15:8]); end
      n_cmp++;
      if (evq[10][15:8] !== 8'h00) begin n_err++; $display("FAIL wrap_k9: got %h want 00", evq[10][15:8]); end
      n_cmp++;
      if (evq[14][15:8] !== 8'h3C) begin n_err++; $display("FAIL wrap_k13: got %h want 3c", evq[14][15:8]); end
    end
    for (int i = 0; i < evq.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (evq[i] !== exp_q[i]) begin n_err++; $display("FAIL wrap_ev[%0d]: got %h want %h", i, evq[i], exp_q[i]); end
    end
  endtask

  task automatic test_backpressure();
    int cyc = 0, nv = 0, n_exp = 0;
    bit stalled = 0;
    logic [AW-1:0] held;
    fill_counts(3, 3);
    cnt_mem[8'h2A] = 8'd2;
    build_exp(8'h2A);
    foreach (exp_q[i]) if (exp_q[i][17:16] == 2'b10) n_exp++;
    evq.delete();
    pulse_start(8'h2A);
    while (!done && cyc < 3000) begin
      @(negedge fast_clk); cyc++;
      if (ifc.nbr_valid) nv++;
      if (nv == 4 && !stalled) begin
        stalled = 1;
        stall_force = 1'b1;
        @(negedge fast_clk);
        held = ifc.nbr_addr;
        n_cmp++;
        if (held !== 7'd2) begin n_err++; $display("FAIL bp_held_addr: got %0d want 2", held); end
        for (int s = 0; s < 5; s++) begin
          if (s > 0) @(negedge fast_clk);
          n_cmp++;
          if (ifc.nbr_valid !== 1'b0 || ifc.nbr_addr !== held) begin
            n_err++; $display("FAIL bp_stall cyc=%0d: got valid=%b addr=%0d want 0/%0d", s, ifc.nbr_valid, ifc.nbr_addr, held);
          end
        end
        stall_force = 1'b0;
      end
    end
    n_cmp++;
    if (done !== 1'b1 || nv != n_exp) begin
      n_err++; $display("FAIL bp_total: got %0d done=%b want %0d done=1", nv, done, n_exp);
    end
    n_cmp++;
    if (evq.size() != exp_q.size()) begin n_err++; $display("FAIL bp_len: got %0d want %0d", evq.size(), exp_q.size()); end
    for (int i = 0; i < evq.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (evq[i] !== exp_q[i]) begin n_err++; $display("FAIL bp_ev[%0d]: got %h want %h", i, evq[i], exp_q[i]); end
    end
  endtask

  task automatic test_drain();
    int cyc = 0, nv = 0;
    bit early = 0;
    fill_counts(1, 1);
    build_exp(8'h05);
    evq.delete();
    drain_idle = 1'b0;
    pulse_start(8'h05);
    while (nv < 14 && cyc < 2000) begin
      @(negedge fast_clk); cyc++;
      if (ifc.nbr_valid) nv++;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge fast_clk);
      if (done) early = 1;
    end
    n_cmp++;
    if (early || nv != 14) begin n_err++; $display("FAIL drain_hold: got early=%0d nv=%0d want 0/14", early, nv); end
    drain_idle = 1'b1;
    wait_done(5, cyc);
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL drain_release: got done=%b busy=%b want 1/0", done, busy);
    end
    n_cmp++;
    if (evq.size() != exp_q.size()) begin n_err++; $display("FAIL drain_len: got %0d want %0d", evq.size(), exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    int cyc = 0, nv = 0;
    logic [7:0] h;
    fill_counts(1, 3);
    h = 8'($urandom_range(0, 63));
    pulse_start(h);
    while (nv < 3 && cyc < 2000) begin
      @(negedge fast_clk); cyc++;
      if (ifc.nbr_valid) nv++;
    end
    reset = 1'b1;
    @(negedge fast_clk);
    n_cmp++;
    if ({busy, done, ifc.ref_load, ifc.nbr_valid, ifc.count_cell, ifc.nbr_cell, ifc.nbr_addr} !== 27'h0) begin
      n_err++; $display("FAIL midreset_outputs: got %h want 0",
        {busy, done, ifc.ref_load, ifc.nbr_valid, ifc.count_cell, ifc.nbr_cell, ifc.nbr_addr});
    end
    reset = 1'b0;
    repeat (2) @(posedge fast_clk);
    build_exp(h);
    evq.delete();
    pulse_start(h);
    wait_done(4000, cyc);
    n_cmp++;
    if (done !== 1'b1 || evq.size() != exp_q.size()) begin
      n_err++; $display("FAIL midreset_rerun_len: got %0d done=%b want %0d", evq.size(), done, exp_q.size());
    end
    for (int i = 0; i < evq.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (evq[i] !== exp_q[i]) begin n_err++; $display("FAIL midreset_ev[%0d]: got %h want %h", i, evq[i], exp_q[i]); end
    end
  endtask

  task automatic test_start_while_busy();
    int cyc = 0, nv = 0;
    fill_counts(1, 4);
    build_exp(8'h12);
    evq.delete();
    pulse_start(8'h12);
    while (nv < 2 && cyc < 2000) begin
      @(negedge fast_clk); cyc++;
      if (ifc.nbr_valid) nv++;
    end
    pulse_start(8'h31);
    wait_done(4000, cyc);
    n_cmp++;
    if (done !== 1'b1 || evq.size() != exp_q.size()) begin
      n_err++; $display("FAIL busy_start_len: got %0d done=%b want %0d", evq.size(), done, exp_q.size());
    end
    for (int i = 0; i < evq.size() && i < exp_q.size(); i++) begin
      n_cmp++;
      if (evq[i] !== exp_q[i]) begin n_err++; $display("FAIL busy_start_ev[%0d]: got %h want %h", i, evq[i], exp_q[i]); end
    end
  endtask

  task automatic test_max_count();
    int cyc;
    logic [7:0] far;
    fill_counts(0, 0);
    cnt_mem[8'h07] = 8'd1;
    far = cell_of(8'h07, 13);
    cnt_mem[far] = 8'd128;
    build_exp(8'h07);
    evq.delete();
    pulse_start(8'h07);
    wait_done(3000, cyc);
    n_cmp++;
    if (done !== 1'b1 || evq.size() != exp_q.size()) begin
      n_err++; $display("FAIL maxcnt_len: got %0d done=%b want %0d", evq.size(), done, exp_q.size());
    end else begin
      n_cmp++;
      if (evq[evq.size()-1] !== {2'b10, far, 8'd127}) begin
        n_err++; $display("FAIL maxcnt_last: got %h want %h", evq[evq.size()-1], {2'b10, far, 8'd127});
      end
    end
  endtask

  task automatic test_random();
    int cyc;
    logic [7:0] h;
    stall_mode = 1;
    for (int it = 0; it < 6; it++) begin
      fill_counts(0, 4);
      h = 8'($urandom_range(0, 63));
      cnt_mem[h] = 8'($urandom_range(0, 3));
      build_exp(h);
      evq.delete();
      pulse_start(h);
      wait_done(6000, cyc);
      n_cmp++;
      if (done !== 1'b1 || evq.size() != exp_q.size()) begin
        n_err++; $display("FAIL rand%0d_len: got %0d done=%b want %0d", it, evq.size(), done, exp_q.size());
      end
      for (int i = 0; i < evq.size() && i < exp_q.size(); i++) begin
        n_cmp++;
        if (evq[i] !== exp_q[i]) begin n_err++; $display("FAIL rand%0d_ev[%0d]: got %h want %h", it, i, evq[i], exp_q[i]); end
      end
    end
    stall_mode = 0;
    n_cmp++;
    if (overlap != 0) begin n_err++; $display("FAIL ref_nbr_overlap: got %0d want 0", overlap); end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    ifc.stall = 1'b0;
    init_shell();
    test_reset();
    test_empty();
    test_single_walk();
    test_wrap();
    test_backpressure();
    test_drain();
    test_reset_mid();
    test_start_while_busy();
    test_max_count();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
